ram64_loader: RTL and testbench

- Bootstrap and clear engine that sits directly upstream of ram64 and drives its in/address/load inputs.
- Load mode: accepts a stream of 16-bit words over a valid/ready handshake and writes them to consecutive ram64 addresses.
- Clear mode: fills a consecutive address range with CLEAR_VALUE, one write per cycle, with no stream input.
- Used at power-up to preload data memory and to zero scratch regions between test programs.

---
 rtl/ram64_loader_pkg.sv | 21 ++
 rtl/ram64_loader.sv | 126 ++++++++++++
 tb/tb_ram64_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram64_loader_pkg.sv
// Shared constants and types for the ram64 bootstrap/clear engine.
// Pure definitions, no logic and therefore no latency.
// No flow control of its own; consumers decide their own handshakes.
package ram64_loader_pkg;

    // ram64 geometry: 64 words of 16 bits (one Hack word each)
    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;

    // Operation FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Operation modes, latched on start
    localparam logic MODE_LOAD  = 1'b0;
    localparam logic MODE_CLEAR = 1'b1;

endpackage : ram64_loader_pkg

// File: rtl/ram64_loader.sv
// Preloads (stream load) or fills (clear) a consecutive, wrapping ram64 address range.
// Write outputs are registered: a word taken at edge E is on the ram64 ports for E..E+1.
// s_ready depends on registered state only; load mode stalls cleanly while s_valid is low.
module ram64_loader #(
    parameter int                          ADDR_W      = ram64_loader_pkg::ADDR_W,
    parameter int                          DATA_W      = ram64_loader_pkg::DATA_W,
    parameter logic [DATA_W-1:0]           CLEAR_VALUE = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   base,
    input  logic [ADDR_W:0]     count,
    input  logic                s_valid,
    input  logic [DATA_W-1:0]   s_data,
    output logic                s_ready,
    output logic [DATA_W-1:0]   mem_in,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_load,
    output logic                busy,
    output logic                done
);

    import ram64_loader_pkg::*;

    // Remaining-word counter must hold the full depth (64), hence one extra bit.
    localparam int              CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]   mem_in_q, mem_in_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_load_q, mem_load_d;
    logic                done_q, done_d;
    logic                rem_zero;
    logic                wr_fire;

    assign rem_zero = (rem_q == '0);

    // Stream acceptance: only in a running load with words still outstanding.
    assign s_ready = (state_q == ST_RUN) && (mode_q == MODE_LOAD) && !rem_zero;

    // A write is issued on a stream handshake, or on every running cycle in clear mode.
    assign wr_fire = (state_q == ST_RUN) && !rem_zero &&
                     ((mode_q == MODE_CLEAR) || s_valid);

    // Next-state and write-port logic; write data/address hold when no write is issued.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        mem_in_d   = mem_in_q;
        mem_addr_d = mem_addr_q;
        mem_load_d = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    ptr_d   = base;
                    // Requests beyond the address space are clipped to one full pass.
                    rem_d   = (count > MAX_COUNT) ? MAX_COUNT : count;
                    state_d = (count == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (wr_fire) begin
                    mem_in_d   = (mode_q == MODE_CLEAR) ? CLEAR_VALUE : s_data;
                    mem_addr_d = ptr_q;
                    mem_load_d = 1'b1;
                    ptr_d      = ptr_q + 1'b1;   // wraps naturally at the top address
                    rem_d      = rem_q - 1'b1;
                end else if (rem_zero) begin
                    // Final write commits on the same edge that enters FIN.
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                // start is deliberately not sampled here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // done is registered so it is high exactly while the FSM sits in FIN.
        done_d = (state_d == ST_FIN);
    end

    // State and output registers; reset aborts any operation and drops mem_load at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_LOAD;
            ptr_q      <= '0;
            rem_q      <= '0;
            mem_in_q   <= '0;
            mem_addr_q <= '0;
            mem_load_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            mem_in_q   <= mem_in_d;
            mem_addr_q <= mem_addr_d;
            mem_load_q <= mem_load_d;
            done_q     <= done_d;
        end
    end

    assign mem_in      = mem_in_q;
    assign mem_address = mem_addr_q;
    assign mem_load    = mem_load_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;

endmodule : ram64_loader

// File: tb/tb_ram64_loader.sv
// Randomized scoreboard bench for ram64_loader with a behavioural ram64 stand-in.
// Expected writes and done edges are queued by stimulus and popped by a negedge monitor.
// Stream gaps are randomized to exercise s_valid stalls.
module tb_ram64_loader;

    localparam logic [15:0] CLR = 16'h0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        mode;
    logic [5:0]  base;
    logic [6:0]  count;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic [15:0] mem_in;
    logic [5:0]  mem_address;
    logic        mem_load;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    ram64_loader #(
        .ADDR_W      (6),
        .DATA_W      (16),
        .CLEAR_VALUE (CLR)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .mode        (mode),
        .base        (base),
        .count       (count),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .mem_in      (mem_in),
        .mem_address (mem_address),
        .mem_load    (mem_load),
        .busy        (busy),
        .done        (done)
    );

    // ram64 stand-in: commits on the rising edge while load is high
    logic [15:0] ram_m [64];
    always @(posedge clk) if (mem_load) ram_m[mem_address] <= mem_in;

    // Reference memory image, maintained from the operation rules alone
    logic [15:0] ref_mem [64];
    logic [15:0] words [64];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [21:0] wq [$];   // {address, data} of each expected write, in order
    int          dq [$];   // edge number at which done is expected to rise
    logic [21:0] mon_w;
    int          mon_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write and every done pulse must match the scoreboard head
    always @(negedge clk) begin
        if (mem_load === 1'b1) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h expected=none t=%0t",
                         mem_address, mem_in, $time);
            end else begin
                mon_w = wq.pop_front();
                chk("write_addr", 32'(mem_address), 32'(mon_w[21:16]));
                chk("write_data", 32'(mem_in), 32'(mon_w[15:0]));
            end
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0 t=%0t", $time);
            end else begin
                mon_d = dq.pop_front();
                chk("done_edge", 32'(cyc), 32'(mon_d));
                chk("load_in_fin", 32'(mem_load), 32'd0);
                chk("busy_in_fin", 32'(busy), 32'd1);
            end
        end
    end

    // One complete operation; gaps of gmin..gmax idle cycles are inserted between stream words
    task automatic run_op(input logic m, input logic [5:0] b, input logic [6:0] c,
                          input int gmin, input int gmax, input bit poke_busy, input bit poke_fin);
        int n, s0, last, t, g;
        logic [5:0]  a;
        logic [15:0] d;
        n = (c > 7'd64) ? 64 : int'(c);
        for (int i = 0; i < n; i++) begin
            a = b + 6'(i);
            d = m ? CLR : words[i];
            wq.push_back({a, d});
            ref_mem[a] = d;
        end
        @(posedge clk); #1;
        start = 1'b1; mode = m; base = b; count = c;
        @(posedge clk); #1;
        start = 1'b0; mode = 1'($urandom); base = 6'($urandom); count = 7'($urandom);
        s0 = cyc;
        last = s0;
        chk("busy_after_start", 32'(busy), 32'd1);
        if (n == 0) begin
            dq.push_back(s0);
        end else if (m) begin
            dq.push_back(s0 + n + 1);
            chk("s_ready_clear", 32'(s_ready), 32'd0);
            if (poke_busy) begin
                @(posedge clk); #1;
                start = 1'b1; mode = 1'b0; base = b + 6'd20; count = 7'd5;
                @(posedge clk); #1;
                start = 1'b0;
                chk("s_ready_after_poke", 32'(s_ready), 32'd0);
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                g = (i == 0) ? 0 : int'($urandom_range(gmin, gmax));
                repeat (g) begin
                    s_valid = 1'b0;
                    s_data  = 16'($urandom);
                    chk("s_ready_gap", 32'(s_ready), 32'd1);
                    @(posedge clk); #1;
                end
                s_valid = 1'b1;
                s_data  = words[i];
                chk("s_ready_word", 32'(s_ready), 32'd1);
                @(posedge clk); #1;
                last = cyc;
            end
            s_valid = 1'b0;
            chk("s_ready_after_last", 32'(s_ready), 32'd0);
            dq.push_back(last + 1);
        end
        t = 0;
        while (done !== 1'b1 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%b expected=1 t=%0t", done, $time);
        end
        if (poke_fin) begin
            start = 1'b1; mode = 1'b1; base = b; count = 7'd9;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_back_idle", 32'(busy), 32'd0);
        chk("queue_drained", 32'(wq.size()), 32'd0);
        // Words offered outside a running load must not be taken
        repeat (2) begin
            s_valid = 1'($urandom);
            s_data  = 16'($urandom);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int j;
        reset_n = 1'b0; start = 1'b0; mode = 1'b0; base = '0; count = '0;
        s_valid = 1'b0; s_data = '0;
        #12;
        chk("rst_mem_in", 32'(mem_in), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_load", 32'(mem_load), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        #10 reset_n = 1'b1;

        // Fill the whole memory with FFFF, then clear a wrapping range
        for (int i = 0; i < 64; i++) words[i] = 16'hFFFF;
        run_op(1'b0, 6'd0, 7'd64, 0, 0, 1'b0, 1'b0);
        run_op(1'b1, 6'd62, 7'd4, 0, 0, 1'b0, 1'b0);
        chk("wrap_62", 32'(ram_m[62]), 32'(CLR));
        chk("wrap_1", 32'(ram_m[1]), 32'(CLR));
        chk("wrap_keep_2", 32'(ram_m[2]), 32'h0000FFFF);

        // Short load, back to back and then with 2-cycle gaps
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        run_op(1'b0, 6'd5, 7'd3, 0, 0, 1'b0, 1'b0);
        chk("load_5", 32'(ram_m[5]), 32'h00001111);
        chk("load_7", 32'(ram_m[7]), 32'h00003333);
        chk("load_keep_8", 32'(ram_m[8]), 32'h0000FFFF);
        run_op(1'b0, 6'd5, 7'd3, 2, 2, 1'b0, 1'b0);
        chk("gap_load_6", 32'(ram_m[6]), 32'h00002222);

        // Zero-length operations, clipped clear with start in FIN, start while busy
        run_op(1'b0, 6'd10, 7'd0, 0, 0, 1'b0, 1'b0);
        run_op(1'b1, 6'd33, 7'd0, 0, 0, 1'b0, 1'b1);
        run_op(1'b1, 6'd10, 7'd100, 0, 0, 1'b0, 1'b1);
        run_op(1'b1, 6'd20, 7'd10, 0, 0, 1'b1, 1'b0);

        // Randomized operations
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 64; i++) words[i] = 16'($urandom);
            run_op(1'($urandom), 6'($urandom),
                   ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 12)),
                   0, int'($urandom_range(0, 2)), 1'b0, 1'($urandom));
        end

        // Reset in the middle of a full clear
        for (int i = 0; i < 64; i++) words[i] = 16'($urandom);
        run_op(1'b0, 6'd0, 7'd64, 0, 0, 1'b0, 1'b0);
        j = 10;
        for (int i = 0; i < j - 1; i++) begin
            wq.push_back({6'(i), CLR});
            ref_mem[i] = CLR;
        end
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b1; base = 6'd0; count = 7'd64;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (j) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("abort_mem_load", 32'(mem_load), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_s_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #3;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_queue_drained", 32'(wq.size()), 32'd0);
        chk("abort_done_queue", 32'(dq.size()), 32'd0);

        for (int a = 0; a < 64; a++) chk("mem_contents", 32'(ram_m[a]), 32'(ref_mem[a]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ram64_loader
